// File: rtl/riscv_fetch_queue_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
// Holds the control FSM encoding and default datapath sizes.
package riscv_fetch_queue_pkg;

   localparam int FQ_XLEN  = 32;
   localparam int FQ_DEPTH = 4;

   typedef enum logic [1:0] {
      FQ_IDLE  = 2'd0,
      FQ_RUN   = 2'd1,
      FQ_FLUSH = 2'd2
   } fq_state_e;

endpackage

// File: rtl/riscv_fq_fifo.sv
// Prefetch buffer: DEPTH words of {pc, instr} with a synchronous clear.
// The head entry is read straight from storage, so it is registered state.
module riscv_fq_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction prefetch queue between imem and IF: credit-limited
// in-order fetch, response buffering and redirect flush.
module riscv_fetch_queue
   import riscv_fetch_queue_pkg::*;
#(
   parameter int              XLEN   = FQ_XLEN,
   parameter int              DEPTH  = FQ_DEPTH,
   parameter logic [XLEN-1:0] RST_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   output logic            o_fq_valid,
   input  logic            i_fq_ready,
   output logic [XLEN-1:0] o_fq_instr,
   output logic [XLEN-1:0] o_fq_pc,
   output logic [XLEN-1:0] o_fq_pc4,
   input  logic            i_fq_redirect,
   input  logic [XLEN-1:0] i_fq_redirect_pc
);

   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] STEP    = XLEN'(4);

   fq_state_e         state;
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   rsp_pc;
   logic [XLEN-1:0]   req_addr;
   logic              req_valid;
   logic              req_stale;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     drop_next;
   logic              stale_next;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit_used;
   logic [2*XLEN-1:0] head;
   logic              req_fire;
   logic              rsp_fire;
   logic              rsp_keep;
   logic              issue;
   logic              push;
   logic              pop;

   assign req_fire = req_valid & i_imem_req_ready;
   assign rsp_fire = i_imem_rsp_valid;
   assign rsp_keep = rsp_fire & (drop_cnt == '0);
   assign push     = rsp_keep & ~i_fq_redirect;
   assign pop      = o_fq_valid & i_fq_ready & ~i_fq_redirect;

   // A pending request already holds a credit even before it is accepted.
   assign credit_used = (CW+1)'(fifo_count)
                      + (CW+1)'(outstanding)
                      + (CW+1)'(req_valid);

   assign issue = (state == FQ_RUN) & ~i_fq_redirect
                & (~req_valid | i_imem_req_ready)
                & (credit_used < CREDITS);

   always_comb begin
      drop_next  = drop_cnt;
      stale_next = req_stale;
      if (i_fq_redirect) begin
         drop_next  = outstanding + CW'(req_fire) - CW'(rsp_fire);
         stale_next = req_valid & ~i_imem_req_ready;
      end else begin
         drop_next  = drop_cnt - CW'(rsp_fire & ~rsp_keep)
                    + CW'(req_fire & req_stale);
         stale_next = req_stale & ~req_fire;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state       <= FQ_IDLE;
         fetch_pc    <= RST_PC;
         rsp_pc      <= RST_PC;
         req_valid   <= 1'b0;
         req_addr    <= '0;
         req_stale   <= 1'b0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
         drop_cnt    <= drop_next;
         req_stale   <= stale_next;

         if (issue) begin
            req_valid <= 1'b1;
            req_addr  <= fetch_pc;
         end else if (req_fire) begin
            req_valid <= 1'b0;
         end

         if (i_fq_redirect)  fetch_pc <= i_fq_redirect_pc;
         else if (issue)     fetch_pc <= fetch_pc + STEP;

         if (i_fq_redirect)  rsp_pc <= i_fq_redirect_pc;
         else if (push)      rsp_pc <= rsp_pc + STEP;

         unique case (state)
            FQ_IDLE: state <= FQ_RUN;
            FQ_RUN: begin
               if (i_fq_redirect && (drop_next != '0 || stale_next))
                  state <= FQ_FLUSH;
            end
            FQ_FLUSH: begin
               if (drop_next == '0 && !stale_next)
                  state <= FQ_RUN;
            end
            default: state <= FQ_IDLE;
         endcase
      end
   end

   riscv_fq_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rstn),
      .clr   (i_fq_redirect),
      .push  (push),
      .pop   (pop),
      .wdata ({rsp_pc, i_imem_rsp_data}),
      .rdata (head),
      .count (fifo_count)
   );

   assign o_imem_req_valid = req_valid;
   assign o_imem_req_addr  = req_addr;
   assign o_fq_valid       = (fifo_count != '0);
   assign o_fq_instr = o_fq_valid ? head[XLEN-1:0] : '0;
   assign o_fq_pc    = o_fq_valid ? head[2*XLEN-1:XLEN] : '0;
   assign o_fq_pc4   = o_fq_valid ? head[2*XLEN-1:XLEN] + STEP : '0;

   assert property (@(posedge i_clk) disable iff (!i_rstn)
      !(i_imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: in-order imem model, IF consumer and a
// scoreboard expecting consecutive PCs from the last reset/redirect target.
`timescale 1ns/1ps
module tb_riscv_fetch_queue;

   localparam int          XLEN   = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        fq_valid;
   logic        fq_ready = 1'b1;
   logic [31:0] fq_instr;
   logic [31:0] fq_pc;
   logic [31:0] fq_pc4;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   always #5 clk = ~clk;

   riscv_fetch_queue #(
      .XLEN   (XLEN),
      .DEPTH  (DEPTH),
      .RST_PC (RST_PC)
   ) dut (
      .i_clk            (clk),
      .i_rstn           (rstn),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (req_ready),
      .o_imem_req_addr  (req_addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .o_fq_valid       (fq_valid),
      .i_fq_ready       (fq_ready),
      .o_fq_instr       (fq_instr),
      .o_fq_pc          (fq_pc),
      .o_fq_pc4         (fq_pc4),
      .i_fq_redirect    (redirect),
      .i_fq_redirect_pc (redirect_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
   } pop_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          total_pops = 0;
   req_t        pend[$];
   logic [31:0] req_log[$];
   logic [31:0] exp_q[$];
   pop_t        pop_log[$];
   int          accept_limit = 1 << 30;
   bit          hold_rsp = 1'b0;
   bit          rand_ready = 1'b0;
   int          lat_max = 1;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_target(input logic [31:0] pc);
      exp_q.delete();
      pop_log.delete();
      for (int i = 0; i < 2048; i++) exp_q.push_back(pc + 32'(4 * i));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // In-order imem with per-request latency; forgets everything on reset.
   initial begin
      req_t r;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pend.delete();
         end else if (req_valid && req_ready) begin
            r.addr = req_addr;
            r.due  = cyc + int'($urandom_range(lat_max, 1));
            pend.push_back(r);
            req_log.push_back(r.addr);
         end
         @(posedge clk);
         #1;
         rsp_valid = 1'b0;
         if (rstn && !hold_rsp && pend.size() > 0 && cyc >= pend[0].due) begin
            rsp_valid = 1'b1;
            rsp_data  = instr_of(pend[0].addr);
            void'(pend.pop_front());
         end
         req_ready = (req_log.size() < accept_limit)
                   && (!rand_ready || $urandom_range(3, 0) != 0);
      end
   end

   // Scoreboard monitor: every IF consumption is checked against the model.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rstn && fq_valid && fq_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: got pc %h expected none", fq_pc);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", fq_pc, e);
               chk("sb_instr", fq_instr, instr_of(e));
               chk("sb_pc4", fq_pc4, e + 32'd4);
            end
            pop_log.push_back('{pc: fq_pc, pc4: fq_pc4});
            total_pops++;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset(input logic ready);
      rstn = 1'b0;
      redirect = 1'b0;
      fq_ready = ready;
      hold_rsp = 1'b0;
      rand_ready = 1'b0;
      lat_max = 1;
      accept_limit = 1 << 30;
      tick(3);
      req_log.delete();
      set_target(RST_PC);
      rstn = 1'b1;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect = 1'b1;
      redirect_pc = pc;
      set_target(pc);
      tick();
      redirect = 1'b0;
   endtask

   task automatic wait_pops(input int n, input string name);
      int k = 0;
      while (pop_log.size() < n && k < 300) begin
         tick();
         k++;
      end
      chk(name, 32'(pop_log.size() >= n), 32'd1);
   endtask

   task automatic wait_reqs(input int n, input string name);
      int k = 0;
      while (req_log.size() < n && k < 300) begin
         tick();
         k++;
      end
      chk(name, 32'(req_log.size() >= n), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int bad;
      logic [31:0] t;

      // 1: reset values, startup latency, sequential fetch
      tick(3);
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_req_addr", req_addr, 32'd0);
      chk("rst_fq_valid", 32'(fq_valid), 32'd0);
      chk("rst_fq_pc", fq_pc, 32'd0);
      chk("rst_fq_pc4", fq_pc4, 32'd0);
      chk("rst_fq_instr", fq_instr, 32'd0);
      req_log.delete();
      set_target(RST_PC);
      rstn = 1'b1;
      tick();
      chk("t1_req_idle", 32'(req_valid), 32'd0);
      tick();
      chk("t1_req_first", 32'(req_valid), 32'd1);
      chk("t1_addr_first", req_addr, RST_PC);
      k = 2;
      while (!fq_valid && k < 50) begin
         tick();
         k++;
      end
      chk("t1_fq_latency", 32'(k), 32'd4);
      chk("t1_head_pc", fq_pc, 32'h0);
      chk("t1_head_pc4", fq_pc4, 32'h4);
      chk("t1_head_instr", fq_instr, instr_of(32'h0));
      wait_reqs(3, "t1_req_wait");
      chk("t1_req0", req_log[0], 32'h0);
      chk("t1_req1", req_log[1], 32'h4);
      chk("t1_req2", req_log[2], 32'h8);

      // 2: IF stalled -> exactly DEPTH requests, then in-order drain
      do_reset(1'b0);
      tick(20);
      chk("t2_req_count", 32'(req_log.size()), 32'(DEPTH));
      chk("t2_req_idle", 32'(req_valid), 32'd0);
      chk("t2_fq_valid", 32'(fq_valid), 32'd1);
      fq_ready = 1'b1;
      wait_pops(4, "t2_pop_wait");
      chk("t2_pop0", pop_log[0].pc, 32'h0);
      chk("t2_pop3", pop_log[3].pc, 32'hC);

      // 3: redirect with three words in flight
      do_reset(1'b1);
      hold_rsp = 1'b1;
      accept_limit = 3;
      wait_reqs(3, "t3_req_wait");
      tick(2);
      do_redirect(32'h100);
      hold_rsp = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (fq_valid) bad++;
         tick();
      end
      chk("t3_flush_empty", 32'(bad), 32'd0);
      accept_limit = 1 << 30;
      wait_pops(1, "t3_pop_wait");
      chk("t3_first_pc", pop_log[0].pc, 32'h100);

      // 4: redirect coinciding with a response and a held request
      do_reset(1'b1);
      hold_rsp = 1'b1;
      accept_limit = 1;
      wait_reqs(1, "t4_req_wait");
      tick(2);
      hold_rsp = 1'b0;
      tick();
      chk("t4_pending_addr", req_addr, 32'h4);
      do_redirect(32'h300);
      chk("t4_held_valid", 32'(req_valid), 32'd1);
      chk("t4_held_addr", req_addr, 32'h4);
      chk("t4_fq_cleared", 32'(fq_valid), 32'd0);
      tick(3);
      chk("t4_still_held", req_addr, 32'h4);
      accept_limit = 1 << 30;
      wait_pops(1, "t4_pop_wait");
      chk("t4_first_pc", pop_log[0].pc, 32'h300);

      // 5: full FIFO, redirect near the top of the address space
      do_reset(1'b0);
      tick(15);
      do_redirect(32'hFFFF_FFF8);
      chk("t5_valid_drop", 32'(fq_valid), 32'd0);
      fq_ready = 1'b1;
      wait_pops(3, "t5_pop_wait");
      chk("t5_pc0", pop_log[0].pc, 32'hFFFF_FFF8);
      chk("t5_pc1", pop_log[1].pc, 32'hFFFF_FFFC);
      chk("t5_pc1_pc4", pop_log[1].pc4, 32'h0);
      chk("t5_pc2", pop_log[2].pc, 32'h0);
      chk("t5_pc2_pc4", pop_log[2].pc4, 32'h4);

      // 6: reset during FLUSH with two words outstanding
      do_reset(1'b1);
      hold_rsp = 1'b1;
      accept_limit = 2;
      wait_reqs(2, "t6_req_wait");
      tick(2);
      do_redirect(32'h400);
      tick();
      rstn = 1'b0;
      #1;
      chk("t6_rst_req_valid", 32'(req_valid), 32'd0);
      chk("t6_rst_req_addr", req_addr, 32'd0);
      chk("t6_rst_fq_valid", 32'(fq_valid), 32'd0);
      chk("t6_rst_fq_pc4", fq_pc4, 32'd0);
      set_target(RST_PC);
      req_log.delete();
      hold_rsp = 1'b0;
      accept_limit = 1 << 30;
      tick(3);
      rstn = 1'b1;
      wait_pops(2, "t6_pop_wait");
      chk("t6_pc0", pop_log[0].pc, RST_PC);
      chk("t6_pc1", pop_log[1].pc, RST_PC + 32'd4);

      // Random traffic: imem stalls/latency, IF stalls, redirects
      do_reset(1'b1);
      rand_ready = 1'b1;
      lat_max = 4;
      k = total_pops;
      for (int i = 0; i < 3000; i++) begin
         fq_ready = ($urandom_range(3, 0) != 0);
         if ($urandom_range(29, 0) == 0) begin
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(3, 0) == 0) t = t | 32'hFFFF_FFF0;
            do_redirect(t);
         end else begin
            tick();
         end
      end
      fq_ready = 1'b1;
      rand_ready = 1'b0;
      tick(30);
      chk("rand_progress", 32'(total_pops - k > 200), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
